// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axil_pkg
// Description : Shared response codes, FSM state types and default ID value
//               for the AXI4-Lite register file responder.
// Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [1:0]  RESP_SLVERR      = 2'b10;
    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA5A1_0001;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_HAVE_A = 2'd1,
        WR_HAVE_D = 2'd2,
        WR_RESP   = 2'd3
    } wr_state_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

endpackage : axil_pkg
`default_nettype wire

// File: rtl/axil_regfile_core.sv
`default_nettype none
// ============================================================================
// Module      : axil_regfile_core
// Description : Register array with byte-strobe writes; register 0 is the ID.
//               AXIL_SLV_WR_CNT_EN turns the last register into a write counter.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_regfile_core
    import axil_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          STRB_W   = 4,
    parameter int          NUM_REGS = 16,
    parameter int          IDX_W    = 4,
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [IDX_W-1:0]           widx,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [STRB_W-1:0]          wstrb,
    input  logic [IDX_W-1:0]           ridx,
    output logic [DATA_W-1:0]          rdata,
    output logic [NUM_REGS*DATA_W-1:0] reg_q
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // The caller only asserts we for writable indices, so reg 0 keeps its ID
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == 0) ? ID_VALUE : '0;
            end
        end else if (we) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (wstrb[k]) begin
                    r_regs[widx][k*8 +: 8] <= wdata[k*8 +: 8];
                end
            end
`ifdef AXIL_SLV_WR_CNT_EN
            r_regs[NUM_REGS-1] <= r_regs[NUM_REGS-1] + 1'b1;
`endif
        end
    end

    assign rdata = r_regs[ridx];

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
            assign reg_q[i*DATA_W +: DATA_W] = r_regs[i];
        end
    endgenerate

endmodule : axil_regfile_core
`default_nettype wire

// File: rtl/axil_regfile_slv.sv
`default_nettype none
// ============================================================================
// Module      : axil_regfile_slv
// Description : AXI4-Lite responder in front of a 32-bit register bank.
//               Optional macro AXIL_SLV_WR_CNT_EN: last register counts writes.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_regfile_slv
    import axil_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int          STRB_W   = 4,
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
    input  logic                       axil_aclk,
    input  logic                       axil_areset,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [ADDR_W-1:0]          s_axil_awaddr,
    input  logic [2:0]                 s_axil_awprot,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    input  logic [DATA_W-1:0]          s_axil_wdata,
    input  logic [STRB_W-1:0]          s_axil_wstrb,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    output logic [1:0]                 s_axil_bresp,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    input  logic [ADDR_W-1:0]          s_axil_araddr,
    input  logic [2:0]                 s_axil_arprot,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    output logic [DATA_W-1:0]          s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        reg_wr_pulse
);

    localparam int                IDX_W      = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] c_num_regs = ADDR_W'(NUM_REGS);
`ifdef AXIL_SLV_WR_CNT_EN
    localparam logic [IDX_W-1:0]  c_cnt_idx  = IDX_W'(NUM_REGS - 1);
`endif

    wr_state_t           r_wr_state, w_wr_state_nxt;
    rd_state_t           r_rd_state, w_rd_state_nxt;
    logic [ADDR_W-1:0]   r_aw_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [1:0]          r_bresp, r_rresp;
    logic [DATA_W-1:0]   r_rdata;
    logic [NUM_REGS-1:0] r_wr_pulse;

    logic                w_aw_hs, w_w_hs, w_ar_hs, w_wr_fire, w_we;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data, w_core_rdata;
    logic [STRB_W-1:0]   w_wr_strb;
    logic [IDX_W-1:0]    w_wr_idx, w_rd_idx;
    logic                w_wr_in, w_rd_in;
    logic [NUM_REGS-1:0] w_onehot;
    logic                w_unused;

    assign s_axil_awready = ~axil_areset & ((r_wr_state == WR_IDLE) | (r_wr_state == WR_HAVE_D));
    assign s_axil_wready  = ~axil_areset & ((r_wr_state == WR_IDLE) | (r_wr_state == WR_HAVE_A));
    assign s_axil_bvalid  = ~axil_areset & (r_wr_state == WR_RESP);
    assign s_axil_bresp   = r_bresp;
    assign s_axil_arready = ~axil_areset & (r_rd_state == RD_IDLE);
    assign s_axil_rvalid  = ~axil_areset & (r_rd_state == RD_RESP);
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = r_rresp;
    assign reg_wr_pulse   = r_wr_pulse;

    assign w_aw_hs = s_axil_awvalid & s_axil_awready;
    assign w_w_hs  = s_axil_wvalid  & s_axil_wready;
    assign w_ar_hs = s_axil_arvalid & s_axil_arready;

    // Whichever half arrived earlier comes from its latch, the other is live
    assign w_wr_addr = (r_wr_state == WR_HAVE_A) ? r_aw_addr : s_axil_awaddr;
    assign w_wr_data = (r_wr_state == WR_HAVE_D) ? r_wdata   : s_axil_wdata;
    assign w_wr_strb = (r_wr_state == WR_HAVE_D) ? r_wstrb   : s_axil_wstrb;
    assign w_wr_idx  = w_wr_addr[2 +: IDX_W];
    assign w_wr_in   = ({2'b00, w_wr_addr[ADDR_W-1:2]} < c_num_regs);
    assign w_rd_idx  = s_axil_araddr[2 +: IDX_W];
    assign w_rd_in   = ({2'b00, s_axil_araddr[ADDR_W-1:2]} < c_num_regs);
    assign w_onehot  = {{(NUM_REGS-1){1'b0}}, 1'b1} << w_wr_idx;

`ifdef AXIL_SLV_WR_CNT_EN
    assign w_we = w_wr_fire & w_wr_in & (w_wr_idx != '0) & (w_wr_idx != c_cnt_idx);
`else
    assign w_we = w_wr_fire & w_wr_in & (w_wr_idx != '0);
`endif

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_fire      = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_wr_state_nxt = WR_RESP;
                    w_wr_fire      = 1'b1;
                end else if (w_aw_hs) begin
                    w_wr_state_nxt = WR_HAVE_A;
                end else if (w_w_hs) begin
                    w_wr_state_nxt = WR_HAVE_D;
                end
            end
            WR_HAVE_A: begin
                if (w_w_hs) begin
                    w_wr_state_nxt = WR_RESP;
                    w_wr_fire      = 1'b1;
                end
            end
            WR_HAVE_D: begin
                if (w_aw_hs) begin
                    w_wr_state_nxt = WR_RESP;
                    w_wr_fire      = 1'b1;
                end
            end
            WR_RESP: begin
                if (s_axil_bready) begin
                    w_wr_state_nxt = WR_IDLE;
                end
            end
            default: w_wr_state_nxt = WR_IDLE;
        endcase
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            RD_IDLE: if (w_ar_hs)       w_rd_state_nxt = RD_RESP;
            RD_RESP: if (s_axil_rready) w_rd_state_nxt = RD_IDLE;
            default:                    w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge axil_aclk) begin
        if (axil_areset) begin
            r_wr_state <= WR_IDLE;
            r_rd_state <= RD_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_ff @(posedge axil_aclk) begin
        if (axil_areset) begin
            r_aw_addr  <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bresp    <= RESP_OKAY;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
            r_wr_pulse <= '0;
        end else begin
            if (w_aw_hs) r_aw_addr <= s_axil_awaddr;
            if (w_w_hs) begin
                r_wdata <= s_axil_wdata;
                r_wstrb <= s_axil_wstrb;
            end
            if (w_wr_fire) r_bresp <= w_wr_in ? RESP_OKAY : RESP_SLVERR;
            r_wr_pulse <= w_we ? w_onehot : '0;
            // Sampled before this edge's write lands, so same-edge reads see old data
            if (w_ar_hs) begin
                r_rdata <= w_rd_in ? w_core_rdata : '0;
                r_rresp <= w_rd_in ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    axil_regfile_core #(
        .DATA_W   (DATA_W),
        .STRB_W   (STRB_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .ID_VALUE (ID_VALUE)
    ) u_core (
        .clk   (axil_aclk),
        .rst   (axil_areset),
        .we    (w_we),
        .widx  (w_wr_idx),
        .wdata (w_wr_data),
        .wstrb (w_wr_strb),
        .ridx  (w_rd_idx),
        .rdata (w_core_rdata),
        .reg_q (reg_q)
    );

    assign w_unused = &{1'b0, s_axil_awprot, s_axil_arprot, w_wr_addr[1:0], s_axil_araddr[1:0]};

endmodule : axil_regfile_slv
`default_nettype wire

// File: tb/tb_axil_regfile_slv.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_regfile_slv
// Description : Directed plus randomized bench for axil_regfile_slv against
//               an array-based register model (AXIL_SLV_WR_CNT_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_regfile_slv;

    localparam int          NREGS = 16;
    localparam logic [31:0] ID    = 32'hA5A1_0001;
`ifdef AXIL_SLV_WR_CNT_EN
    localparam bit          CNT_EN = 1'b1;
`else
    localparam bit          CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              areset;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [31:0]       awaddr, wdata, araddr, rdata;
    logic [3:0]        wstrb;
    logic [2:0]        awprot, arprot;
    logic [1:0]        bresp, rresp;
    logic [NREGS*32-1:0] reg_q;
    logic [NREGS-1:0]  reg_wr_pulse;

    logic [31:0] mregs [NREGS];
    logic [31:0] mcnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    axil_regfile_slv dut (
        .axil_aclk      (clk),
        .axil_areset    (areset),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_awaddr  (awaddr),
        .s_axil_awprot  (awprot),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_bresp   (bresp),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_araddr  (araddr),
        .s_axil_arprot  (arprot),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .reg_q          (reg_q),
        .reg_wr_pulse   (reg_wr_pulse)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_reg(input int i);
        if (i == 0) return ID;
        if (CNT_EN && i == NREGS-1) return mcnt;
        return mregs[i];
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return a[31:2] < NREGS;
    endfunction

    function automatic int reg_mismatches();
        int n = 0;
        for (int i = 0; i < NREGS; i++) begin
            if (reg_q[i*32 +: 32] !== exp_reg(i)) n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) mregs[i] = '0;
        mcnt = '0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        #1;
        check_eq("rst_hs_comb", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hs", {awready, wready, arready, bvalid, rvalid}, 5'b0);
        check_eq("rst_resp", {bresp, rresp, rdata, reg_wr_pulse}, '0);
        areset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_eq("rst_regs", reg_mismatches(), 0);
    endtask

    // mode 0: AW+W together, 1: W first, 2: AW first; bdly<0 leaves B pending
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int mode, input int gap,
                             input int bdly);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int cyc = 0, since = 0, idx;
        bit eff;
        logic [1:0]  exp_resp;
        logic [15:0] exp_pulse;
        if (mode != 1) begin awvalid = 1; awaddr = addr; end
        if (mode != 2) begin wvalid = 1; wdata = data; wstrb = strb; end
        while (!(aw_done && w_done) && cyc < 50) begin
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk);
            #1;
            cyc++;
            if (hs_aw) begin awvalid = 0; aw_done = 1; awaddr = $urandom; end
            if (hs_w)  begin wvalid = 0; w_done = 1; wdata = $urandom; end
            if (w_done && !aw_done) check_eq("wready_hold", wready, 1'b0);
            if (aw_done && !w_done) check_eq("awready_hold", awready, 1'b0);
            if (aw_done != w_done) begin
                since++;
                if (since > gap) begin
                    if (!aw_done && !awvalid) begin awvalid = 1; awaddr = addr; end
                    if (!w_done && !wvalid) begin wvalid = 1; wdata = data; wstrb = strb; end
                end
            end
        end
        check_eq("wr_hs", {aw_done, w_done}, 2'b11);
        idx       = int'(addr[5:2]);
        eff       = in_range(addr) && idx != 0 && !(CNT_EN && idx == NREGS-1);
        exp_resp  = in_range(addr) ? 2'b00 : 2'b10;
        exp_pulse = eff ? (16'h1 << idx) : 16'h0;
        if (eff) begin
            for (int k = 0; k < 4; k++)
                if (strb[k]) mregs[idx][k*8 +: 8] = data[k*8 +: 8];
            if (CNT_EN) mcnt = mcnt + 1;
        end
        check_eq("bvalid", bvalid, 1'b1);
        check_eq("bresp", bresp, exp_resp);
        check_eq("wr_pulse", reg_wr_pulse, exp_pulse);
        check_eq("regs_after_wr", reg_mismatches(), 0);
        if (bdly >= 0) begin
            for (int i = 0; i < bdly; i++) begin
                @(posedge clk);
                #1;
                check_eq("b_hold", {bvalid, bresp}, {1'b1, exp_resp});
                check_eq("b_hold_rdy", {awready, wready, reg_wr_pulse}, '0);
            end
            bready = 1;
            @(posedge clk);
            #1;
            bready = 0;
            check_eq("b_done", bvalid, 1'b0);
            check_eq("wr_accept", {awready, wready}, 2'b11);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, input int rdly);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        bit hs, done = 0;
        int cyc = 0;
        exp_data = in_range(addr) ? exp_reg(int'(addr[5:2])) : 32'h0;
        exp_resp = in_range(addr) ? 2'b00 : 2'b10;
        arvalid = 1; araddr = addr;
        while (!done && cyc < 50) begin
            hs = arvalid && arready;
            @(posedge clk);
            #1;
            cyc++;
            if (hs) begin arvalid = 0; done = 1; araddr = $urandom; end
        end
        check_eq("rd_hs", done, 1'b1);
        check_eq("rvalid", rvalid, 1'b1);
        check_eq("rdata", rdata, exp_data);
        check_eq("rresp", rresp, exp_resp);
        for (int i = 0; i < rdly; i++) begin
            @(posedge clk);
            #1;
            check_eq("r_hold", {rvalid, rresp, rdata}, {1'b1, exp_resp, exp_data});
            check_eq("r_hold_rdy", arready, 1'b0);
        end
        rready = 1;
        @(posedge clk);
        #1;
        rready = 0;
        check_eq("r_done", rvalid, 1'b0);
        check_eq("rd_accept", arready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        areset = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; awprot = 0; arprot = 0;
        model_reset();
        do_reset();
        check_eq("id_reg_q", reg_q[31:0], 32'hA5A1_0001);

        axi_write(32'h8, 32'h1234_5678, 4'hF, 0, 0, 0);
        check_eq("reg2", reg_q[95:64], 32'h1234_5678);
        axi_write(32'h4, 32'hFFFF_FFFF, 4'h3, 1, 3, 0);
        check_eq("reg1", reg_q[63:32], 32'h0000_FFFF);
        axi_read(32'h0, 0);
        axi_write(32'h0, 32'h0000_DEAD, 4'hF, 0, 0, 0);
        axi_write(32'h40, 32'h5555_AAAA, 4'hF, 2, 1, 0);
        axi_read(32'h44, 0);
        axi_write(32'hC, 32'h0BAD_CAFE, 4'hF, 2, 2, 5);
        axi_read(32'h8, 5);
        fork
            axi_write(32'h8, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
            axi_read(32'h8, 0);
        join

        do_reset();
        axi_write(32'h4, 32'h1, 4'hF, 0, 0, 0);
        axi_write(32'h8, 32'h2, 4'hF, 1, 0, 0);
        axi_write(32'hC, 32'h3, 4'hF, 2, 0, 0);
        axi_write(32'h0, 32'h4, 4'hF, 0, 0, 0);
        axi_read(32'h3C, 0);
        axi_write(32'h4, 32'h77, 4'hF, 0, 0, -1);
        do_reset();
        axi_read(32'h3C, 0);

        for (int n = 0; n < 150; n++) begin
            a = ($urandom_range(0, 19) << 2) | ($urandom & 32'h3);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 2),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            else
                axi_read(a, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_axil_regfile_slv
`default_nettype wire
